// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the instruction condition against the
// stored NZCV flags, gates the PC/register/memory writes and updates the flags.
module cond_logic #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondExReg
);

    logic [3:0] flags_r;
    logic       cond_ex_r;
    logic       cond_ex_s;
    logic [1:0] flag_write_s;

    // Full 16-entry condition table; code 1111 never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic res;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Condition evaluation and write gating; uses stored flags only, so an
    // instruction never sees the flags it produces itself.
    always_comb begin
        cond_ex_s    = cond_eval(Cond, flags_r);
        flag_write_s = FlagW & {2{cond_ex_s}};
        PCSrc        = PCS & cond_ex_s;
        RegWrite     = RegW & cond_ex_s & ~NoWrite;
        MemWrite     = MemW & cond_ex_s;
    end

    // Flag storage: N,Z and C,V halves are written independently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= FLAGS_RST;
        end else begin
            if (flag_write_s[1]) begin
                flags_r[3:2] <= ALUFlags[3:2];
            end else begin
                flags_r[3:2] <= flags_r[3:2];
            end
            if (flag_write_s[0]) begin
                flags_r[1:0] <= ALUFlags[1:0];
            end else begin
                flags_r[1:0] <= flags_r[1:0];
            end
        end
    end

    // One-cycle-late copy of the condition result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_ex_r <= 1'b0;
        end else begin
            cond_ex_r <= cond_ex_s;
        end
    end

    assign Flags     = flags_r;
    assign CondExReg = cond_ex_r;

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: directed scenarios plus random stimulus,
// checked against a pair-and-invert reference model of the condition codes.
module tb_cond_logic;

    localparam logic [3:0] RST_VAL = 4'b0000;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondExReg;

    cond_logic #(.FLAGS_RST(RST_VAL)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .CondExReg(CondExReg)
    );

    typedef struct {
        logic       pc;
        logic       rw;
        logic       mw;
        logic [3:0] fl;
        logic       cer;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0] m_flags;
    logic       m_cer;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Condition codes come in complementary pairs: the low bit inverts the
    // base test of cond[3:1]; 1111 is the never-execute exception.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a settled output every cycle; compare at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("PCSrc",     {3'b000, PCSrc},     {3'b000, e.pc});
                chk("RegWrite",  {3'b000, RegWrite},  {3'b000, e.rw});
                chk("MemWrite",  {3'b000, MemWrite},  {3'b000, e.mw});
                chk("Flags",     Flags,               e.fl);
                chk("CondExReg", {3'b000, CondExReg}, {3'b000, e.cer});
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge, push the expected
    // response, then advance the model across the next edge.
    task automatic step(input logic rst, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic pcs, input logic rw,
                        input logic mw, input logic nw);
        exp_t e;
        logic [3:0] fl_now;
        logic       cex;
        @(posedge clk);
        #1;
        reset = rst; Cond = c; ALUFlags = af; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        fl_now = rst ? RST_VAL : m_flags;
        cex    = ref_cond(c, fl_now);
        e.pc   = pcs && cex;
        e.rw   = rw && cex && !nw;
        e.mw   = mw && cex;
        e.fl   = fl_now;
        e.cer  = rst ? 1'b0 : m_cer;
        sb_q.push_back(e);
        if (rst) begin
            m_flags = RST_VAL;
            m_cer   = 1'b0;
        end else begin
            m_cer = cex;
            if (fw[1] && cex) m_flags[3:2] = af[3:2];
            if (fw[0] && cex) m_flags[1:0] = af[1:0];
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        step(1'b0, 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; Cond = 4'b0; ALUFlags = 4'b0; FlagW = 2'b0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        m_flags = RST_VAL;
        m_cer   = 1'b0;

        // Reset, then a failed EQ must suppress every effect.
        step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Compare-class write: no register write, flags visible next cycle.
        step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

        // Partial write keeps C,V.
        set_flags(4'b0011);
        step(1'b0, 4'b1110, 4'b1100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle overrides a same-cycle flag write.
        set_flags(4'b1010);
        step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1110, 4'b0101, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Registered CondEx: never, always, always.
        step(1'b0, 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full sweep: every condition against every stored flag value.
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++)
                step(1'b0, 4'(c), 4'($urandom_range(15)), 2'b00, 1'b1, 1'b1, 1'b1,
                     1'($urandom_range(1)));
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(63) == 0), 4'($urandom_range(15)), 4'($urandom_range(15)),
                 2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));

        // Drain: every pushed expectation must have been consumed.
        repeat (3) @(posedge clk);
        chk("drain", 4'(sb_q.size()), 4'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
